prio_encoder_rr: RTL and testbench

//  Parametrised N-to-log2(N) encoder with a registered output and valid/ready handshakes.
//  Two modes:
//   - Fixed priority: the highest set index wins.
//   - Round-robin: a rotating pointer selects the winner.
//  It also flags an all-zero request word and a request word with more than one bit set.

---
 rtl/prio_encoder_rr.sv | 114 +++++++++++
 tb/tb_prio_encoder_rr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// Purpose     : N-to-log2(N) request encoder, fixed-priority (highest index) or round-robin.
// Latency     : 1 cycle from accept to out_valid; 1 result per cycle when out_ready is held high.
// Backpressure: in_ready = !out_valid || out_ready; a held result stays frozen while stalled.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake; req is sampled only on accept
//   req[N-1:0]           request word, bit k = input k
//   out_valid/out_ready  result handshake
//   code[W-1:0]          winning index
//   none / multi         accepted req was all-zero / had two or more bits set
module prio_encoder_rr #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] code,
    output logic         none,
    output logic         multi
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] code_q, code_d;
    logic         none_q, none_d;
    logic         multi_q, multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic         any_req;
    logic [W-1:0] win;
    logic [W-1:0] fix_win;   // highest set index
    logic [W-1:0] hi_win;    // lowest set index at or above ptr
    logic         hi_found;
    logic [W-1:0] lo_win;    // lowest set index overall (used when the search wraps)

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign any_req  = |req;

    // Round-robin search ptr..N-1 then 0..ptr-1 is split into two scans: the lowest
    // set bit at/above ptr, else the lowest set bit overall. Avoids a modulo index.
    always_comb begin
        fix_win  = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        lo_win   = '0;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                fix_win = W'(k);
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo_win = W'(k);
                if (k >= int'(ptr_q)) begin
                    hi_win   = W'(k);
                    hi_found = 1'b1;
                end
            end
        end
    end

    assign win = (MODE == 0) ? fix_win : (hi_found ? hi_win : lo_win);

    always_comb begin
        out_valid_d = out_valid_q;
        code_d      = code_q;
        none_d      = none_q;
        multi_d     = multi_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            code_d      = win;
            none_d      = !any_req;
            // Clearing the lowest set bit leaves something only if two or more were set.
            multi_d     = |(req & (req - N'(1)));
            // Pointer wraps at N, not 2^W, so non-power-of-two N stays in range.
            if (MODE != 0 && any_req) begin
                ptr_d = (win == W'(N - 1)) ? '0 : win + W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            none_q      <= 1'b0;
            multi_q     <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            none_q      <= none_d;
            multi_q     <= multi_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign code      = code_q;
    assign none      = none_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Purpose     : directed bench for prio_encoder_rr in fixed (N=8), round-robin (N=8) and round-robin (N=5) builds.
// Latency     : checks results 1 cycle after accept, sampled #1 after the rising edge.
// Backpressure: exercises stall, release-with-accept and drain on the fixed-priority instance.
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: MODE=0, N=8
    logic       a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [7:0] a_req = '0;
    logic       a_in_ready, a_out_valid, a_none, a_multi;
    logic [2:0] a_code;
    // Instance B: MODE=1, N=8
    logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0] b_req = '0;
    logic       b_in_ready, b_out_valid, b_none, b_multi;
    logic [2:0] b_code;
    // Instance C: MODE=1, N=5
    logic       c_in_valid = 1'b0, c_out_ready = 1'b0;
    logic [4:0] c_req = '0;
    logic       c_in_ready, c_out_valid, c_none, c_multi;
    logic [2:0] c_code;

    int n_vec = 0;
    int n_err = 0;

    prio_encoder_rr #(.N(8), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .req(a_req),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .code(a_code), .none(a_none), .multi(a_multi));
    prio_encoder_rr #(.N(8), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .req(b_req),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .code(b_code), .none(b_none), .multi(b_multi));
    prio_encoder_rr #(.N(5), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .req(c_req),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .code(c_code), .none(c_none), .multi(c_multi));

    // Delivery log for instance A, used to prove nothing is lost or duplicated under backpressure.
    logic     mon_en = 1'b0;
    int       mon_q[$];
    always @(posedge clk) begin
        if (mon_en && a_out_valid && a_out_ready) mon_q.push_back(int'(a_code));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_in_valid = 1'b1; a_req = 8'h80; a_out_ready = 1'b0;
        tick();
        n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL t1_pre_valid got %b exp 1", a_out_valid); end
        n_vec++; if (a_code !== 3'd7) begin n_err++; $display("FAIL t1_pre_code got %0d exp 7", a_code); end
        tick();
        n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL t1_stall_in_ready got %b exp 0", a_in_ready); end
        // Assert reset mid-cycle, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL t1_rst_valid got %b exp 0", a_out_valid); end
        n_vec++; if (a_code !== 3'd0) begin n_err++; $display("FAIL t1_rst_code got %0d exp 0", a_code); end
        n_vec++; if ({a_none, a_multi} !== 2'b00) begin n_err++; $display("FAIL t1_rst_flags got %b exp 00", {a_none, a_multi}); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL t1_rst_in_ready got %b exp 1", a_in_ready); end
        n_vec++; if ({b_out_valid, c_out_valid} !== 2'b00) begin n_err++; $display("FAIL t1_rst_bc_valid got %b exp 00", {b_out_valid, c_out_valid}); end
        a_in_valid = 1'b0; a_req = '0;
        tick();
        rst_n = 1'b1;
        // First accept on the first edge after release.
        a_in_valid = 1'b1; a_req = 8'h02;
        tick();
        n_vec++; if (a_out_valid !== 1'b1 || a_code !== 3'd1) begin n_err++; $display("FAIL t1_first_accept got valid=%b code=%0d exp valid=1 code=1", a_out_valid, a_code); end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL t1_drain_valid got %b exp 0", a_out_valid); end
    endtask

    task automatic test_fixed_stream();
        logic [7:0] reqs  [4] = '{8'h01, 8'h80, 8'h24, 8'h00};
        logic [2:0] codes [4] = '{3'd0, 3'd7, 3'd5, 3'd0};
        logic       multis[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       nones [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        a_out_ready = 1'b1; a_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_req = reqs[i];
            tick();
            n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid[%0d] got %b exp 1", i, a_out_valid); end
            n_vec++; if (a_code !== codes[i]) begin n_err++; $display("FAIL t2_code[%0d] got %0d exp %0d", i, a_code, codes[i]); end
            n_vec++; if (a_multi !== multis[i]) begin n_err++; $display("FAIL t2_multi[%0d] got %b exp %b", i, a_multi, multis[i]); end
            n_vec++; if (a_none !== nones[i]) begin n_err++; $display("FAIL t2_none[%0d] got %b exp %b", i, a_none, nones[i]); end
        end
        a_in_valid = 1'b0;
        tick();
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL t2_idle_valid got %b exp 0", a_out_valid); end
    endtask

    task automatic test_rotation();
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_vec++; if (b_out_valid !== 1'b1 || b_code !== 3'(i % 8)) begin n_err++; $display("FAIL t3_code[%0d] got valid=%b code=%0d exp valid=1 code=%0d", i, b_out_valid, b_code, i % 8); end
            n_vec++; if (b_multi !== 1'b1 || b_none !== 1'b0) begin n_err++; $display("FAIL t3_flags[%0d] got multi=%b none=%b exp multi=1 none=0", i, b_multi, b_none); end
        end
        b_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_skip_zeros();
        // Pointer is 1 here; a lone bit 5 moves it to 6.
        b_in_valid = 1'b1; b_req = 8'h20;
        tick();
        n_vec++; if (b_code !== 3'd5) begin n_err++; $display("FAIL t4_setup_code got %0d exp 5", b_code); end
        b_req = 8'h41;
        tick();
        n_vec++; if (b_code !== 3'd6 || b_multi !== 1'b1) begin n_err++; $display("FAIL t4_first got code=%0d multi=%b exp code=6 multi=1", b_code, b_multi); end
        tick();
        n_vec++; if (b_code !== 3'd0) begin n_err++; $display("FAIL t4_wrap got code=%0d exp 0", b_code); end
        b_req = 8'h00;
        tick();
        n_vec++; if (b_none !== 1'b1 || b_code !== 3'd0 || b_multi !== 1'b0) begin n_err++; $display("FAIL t4_zero got none=%b code=%0d multi=%b exp none=1 code=0 multi=0", b_none, b_code, b_multi); end
        // Pointer must still be 1 after the all-zero accept.
        b_req = 8'hFF;
        tick();
        n_vec++; if (b_code !== 3'd1) begin n_err++; $display("FAIL t4_ptr_hold got code=%0d exp 1", b_code); end
        b_in_valid = 1'b0;
        tick();
        n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL t4_idle_valid got %b exp 0", b_out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] stall_reqs[3] = '{8'h08, 8'h10, 8'h20};
        mon_q.delete();
        mon_en = 1'b1;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_req = 8'h04;
        tick();
        n_vec++; if (a_out_valid !== 1'b1 || a_code !== 3'd2) begin n_err++; $display("FAIL t5_load got valid=%b code=%0d exp valid=1 code=2", a_out_valid, a_code); end
        for (int k = 0; k < 3; k++) begin
            a_req = stall_reqs[k];
            #1;
            n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL t5_in_ready[%0d] got %b exp 0", k, a_in_ready); end
            tick();
            n_vec++; if (a_out_valid !== 1'b1 || a_code !== 3'd2) begin n_err++; $display("FAIL t5_frozen[%0d] got valid=%b code=%0d exp valid=1 code=2", k, a_out_valid, a_code); end
        end
        a_out_ready = 1'b1; a_req = 8'h40;
        #1;
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL t5_release_in_ready got %b exp 1", a_in_ready); end
        tick();
        n_vec++; if (a_out_valid !== 1'b1 || a_code !== 3'd6) begin n_err++; $display("FAIL t5_no_bubble got valid=%b code=%0d exp valid=1 code=6", a_out_valid, a_code); end
        a_req = 8'h01;
        tick();
        n_vec++; if (a_code !== 3'd0 || a_none !== 1'b0) begin n_err++; $display("FAIL t5_next got code=%0d none=%b exp code=0 none=0", a_code, a_none); end
        a_in_valid = 1'b0;
        tick();
        mon_en = 1'b0;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL t5_drain_valid got %b exp 0", a_out_valid); end
        n_vec++;
        if (mon_q.size() != 3) begin
            n_err++; $display("FAIL t5_delivery_count got %0d exp 3", mon_q.size());
        end else if (mon_q[0] != 2 || mon_q[1] != 6 || mon_q[2] != 0) begin
            n_err++; $display("FAIL t5_delivery_order got %0d,%0d,%0d exp 2,6,0", mon_q[0], mon_q[1], mon_q[2]);
        end
    endtask

    task automatic test_n5();
        logic [4:0] reqs [5] = '{5'b10000, 5'b00001, 5'b11111, 5'b10001, 5'b10001};
        logic [2:0] codes[5] = '{3'd4, 3'd0, 3'd1, 3'd4, 3'd0};
        c_out_ready = 1'b1; c_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_req = reqs[i];
            tick();
            n_vec++; if (c_out_valid !== 1'b1 || c_code !== codes[i]) begin n_err++; $display("FAIL t6_code[%0d] got valid=%b code=%0d exp valid=1 code=%0d", i, c_out_valid, c_code, codes[i]); end
            n_vec++; if (c_code > 3'd4) begin n_err++; $display("FAIL t6_range[%0d] got %0d exp <=4", i, c_code); end
        end
        c_in_valid = 1'b0;
        tick();
        n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL t6_idle_valid got %b exp 0", c_out_valid); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_fixed_stream();
        test_rotation();
        test_skip_zeros();
        test_backpressure();
        test_n5();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d vectors", n_vec);
        $fatal(1, "timeout");
    end

endmodule
